// File: rtl/mem_req_deframer_pkg.sv
// Shared opcodes, FSM state encoding and header byte-0 field offsets for the request deframer.
package mem_req_deframer_pkg;

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_ERASE = 2'd3;

    localparam int B0_OP_LSB  = 0;
    localparam int B0_OP_MSB  = 3;
    localparam int B0_SRC_LSB = 6;
    localparam int B0_SRC_MSB = 7;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_A2   = 3'd1,
        S_A1   = 3'd2,
        S_A0   = 3'd3,
        S_LEN  = 3'd4,
        S_DESC = 3'd5,
        S_DATA = 3'd6
    } state_t;

    // Only the 4-bit codes 1..3 are legal; the upper opcode bits must be zero.
    function automatic logic op_legal(input logic [3:0] op);
        return (op[3:2] == 2'b00) && (op[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_req_deframer_fifo.sv
// mem_byte_fifo: registered byte FIFO, power-of-2 DEPTH, synchronous flush.
// Latency 1 cycle push-to-visible; push ignored when full, pop ignored when empty.
module mem_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Storage is not reset, so hide stale contents while empty.
    assign pop_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mem_req_deframer.sv
// Turns the bus byte stream into flash request descriptors; WRITE payload goes through a byte FIFO.
// Descriptor 1 cycle after last header byte; in_ready low while a descriptor waits or the FIFO is full.
// Optional MEM_DEFRAMER_TIMEOUT_EN aborts frames stalled mid-header or mid-payload.
module mem_req_deframer
    import mem_req_deframer_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [1:0]  req_op,
    output logic [23:0] req_addr,
    output logic [8:0]  req_len,
    output logic [1:0]  req_src,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        err_opcode,
    output logic        err_timeout
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 8-bit idle counter");
    end

    state_t     state;
    logic [8:0] data_cnt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       accept;
    logic       push;
    logic       timeout_hit;

    always_comb begin
        in_ready = 1'b1;
        case (state)
            S_DESC:  in_ready = 1'b0;
            S_DATA:  in_ready = !fifo_full;
            default: in_ready = 1'b1;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign push     = accept && (state == S_DATA);
    assign wr_valid = !fifo_empty;
    assign busy     = (state != S_OP) || !fifo_empty;

`ifdef MEM_DEFRAMER_TIMEOUT_EN
    logic [7:0] idle_cnt;
    logic       timed;

    // Waiting for req_ready in S_DESC is the consumer's stall, not the sender's.
    assign timed       = (state inside {S_A2, S_A1, S_A0, S_LEN, S_DATA});
    assign timeout_hit = timed && !accept && (idle_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt    <= 8'd0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if (!timed || accept || timeout_hit) idle_cnt <= 8'd0;
            else                                 idle_cnt <= idle_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_OP;
            req_valid  <= 1'b0;
            req_op     <= 2'd0;
            req_addr   <= 24'd0;
            req_len    <= 9'd0;
            req_src    <= 2'd0;
            data_cnt   <= 9'd0;
            err_opcode <= 1'b0;
        end else begin
            err_opcode <= 1'b0;
            if (timeout_hit) begin
                state <= S_OP;
            end else begin
                case (state)
                    S_OP: if (accept) begin
                        if (op_legal(in_data[B0_OP_MSB:B0_OP_LSB])) begin
                            req_op  <= in_data[B0_OP_LSB+1:B0_OP_LSB];
                            req_src <= in_data[B0_SRC_MSB:B0_SRC_LSB];
                            state   <= S_A2;
                        end else begin
                            err_opcode <= 1'b1;
                        end
                    end
                    S_A2: if (accept) begin
                        req_addr[23:16] <= in_data;
                        state           <= S_A1;
                    end
                    S_A1: if (accept) begin
                        req_addr[15:8] <= in_data;
                        state          <= S_A0;
                    end
                    S_A0: if (accept) begin
                        req_addr[7:0] <= in_data;
                        if (req_op == OP_ERASE) begin
                            req_len   <= 9'd0;
                            req_valid <= 1'b1;
                            state     <= S_DESC;
                        end else begin
                            state <= S_LEN;
                        end
                    end
                    S_LEN: if (accept) begin
                        // Length is sent minus one so 0xFF encodes a full 256-byte page.
                        req_len   <= {1'b0, in_data} + 9'd1;
                        req_valid <= 1'b1;
                        state     <= S_DESC;
                    end
                    S_DESC: if (req_ready) begin
                        req_valid <= 1'b0;
                        if (req_op == OP_WRITE) begin
                            data_cnt <= req_len;
                            state    <= S_DATA;
                        end else begin
                            state <= S_OP;
                        end
                    end
                    S_DATA: if (accept) begin
                        data_cnt <= data_cnt - 9'd1;
                        if (data_cnt == 9'd1) state <= S_OP;
                    end
                    default: state <= S_OP;
                endcase
            end
        end
    end

    mem_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (timeout_hit),
        .push      (push),
        .push_data (in_data),
        .pop       (wr_ready),
        .pop_data  (wr_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_mem_req_deframer.sv
// Randomized bench for mem_req_deframer: frames are built from the header rules and a scoreboard
// holds the descriptors and payload bytes that must come out, in order.
`timescale 1ns/1ps
module tb_mem_req_deframer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [1:0]  req_op;
    logic [23:0] req_addr;
    logic [8:0]  req_len;
    logic [1:0]  req_src;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [7:0]  wr_data;
    logic        busy;
    logic        err_opcode;
    logic        err_timeout;

    typedef struct packed {
        logic [1:0]  op;
        logic [23:0] addr;
        logic [8:0]  len;
        logic [1:0]  src;
    } desc_t;

    desc_t      exp_desc[$];
    logic [7:0] exp_wr[$];
    desc_t      mon_d;
    logic [7:0] mon_b;

    int n_checks = 0;
    int n_fail = 0;
    int err_op_seen = 0;
    int err_to_seen = 0;
    int exp_err_op = 0;
    int in_acc = 0;

    logic rr_rand = 1'b0, rr_val = 1'b0;
    logic wr_rand = 1'b0, wr_val = 1'b0;

    mem_req_deframer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_src     (req_src),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .busy        (busy),
        .err_opcode  (err_opcode),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Consumer-side ready generators, updated just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        req_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
        wr_ready  = wr_rand ? 1'($urandom_range(0, 1)) : wr_val;
    end

    // Handshakes seen at the falling edge complete at the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) in_acc++;
            if (err_opcode) err_op_seen++;
            if (err_timeout) err_to_seen++;
            if (req_valid && req_ready) begin
                if (exp_desc.size() == 0) begin
                    check("unexpected_desc", 32'd1, 32'd0);
                end else begin
                    mon_d = exp_desc.pop_front();
                    check("desc_op", 32'(req_op), 32'(mon_d.op));
                    check("desc_addr", 32'(req_addr), 32'(mon_d.addr));
                    check("desc_len", 32'(req_len), 32'(mon_d.len));
                    check("desc_src", 32'(req_src), 32'(mon_d.src));
                end
            end
            if (wr_valid && wr_ready) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    mon_b = exp_wr.pop_front();
                    check("wr_data", 32'(wr_data), 32'(mon_b));
                end
            end
        end
    end

    // Called and returns just after a rising edge; byte is accepted on the last edge waited.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] opn, input logic [1:0] src, input logic [23:0] addr,
                              input int len, input bit fixed);
        desc_t d;
        logic [7:0] b;
        send_byte({src, 2'($urandom_range(0, 3)), opn});
        if (!(opn inside {4'd1, 4'd2, 4'd3})) begin
            exp_err_op++;
            check("err_opcode_pulse", 32'(err_opcode), 32'd1);
            return;
        end
        d = '{op: opn[1:0], addr: addr, len: (opn == 4'd3) ? 9'd0 : 9'(len), src: src};
        exp_desc.push_back(d);
        send_byte(addr[23:16]);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        if (opn != 4'd3) send_byte(8'(len - 1));
        check("req_valid_latency", 32'(req_valid), 32'd1);
        if (opn == 4'd2) begin
            for (int i = 0; i < len; i++) begin
                b = fixed ? 8'hAA + 8'(17 * i) : 8'($urandom);
                exp_wr.push_back(b);
                send_byte(b);
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while ((busy || req_valid || exp_desc.size() != 0 || exp_wr.size() != 0) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(n < limit), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_errs", 32'({err_opcode, err_timeout}), 32'd0);
        check("rst_req_fields", 32'({req_op, req_len, req_src}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // READ 01 12 34 56 0F
        rr_val = 1'b1;
        wr_val = 1'b0;
        send_frame(4'h1, 2'd0, 24'h123456, 16, 1'b0);
        wait_idle("read_idle", 100);
        check("read_no_wr", 32'(wr_valid), 32'd0);

        // WRITE src=2, 3 bytes AA BB CC held in FIFO, then drained
        send_frame(4'h2, 2'd2, 24'h000100, 3, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("wr_held_valid", 32'(wr_valid), 32'd1);
        check("wr_held_head", 32'(wr_data), 32'hAA);
        check("wr_held_busy", 32'(busy), 32'd1);
        wr_val = 1'b1;
        wait_idle("write_drain", 100);

        // Descriptor backpressure
        rr_val = 1'b0;
        fork
            send_frame(4'h2, 2'd1, 24'hABCDEF, 5, 1'b0);
            begin
                n = 0;
                while (!req_valid && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                repeat (10) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                    check("bp_req_valid", 32'(req_valid), 32'd1);
                    check("bp_req_addr", 32'(req_addr), 32'hABCDEF);
                    check("bp_req_len", 32'(req_len), 32'd5);
                end
                @(posedge clk);
                #1;
                rr_val = 1'b1;
            end
        join
        wait_idle("bp_drain", 200);

        // FIFO full: only FIFO_DEPTH payload bytes enter while wr_ready is low
        wr_val = 1'b0;
        base = in_acc;
        fork
            send_frame(4'h2, 2'd3, 24'h00F000, 8, 1'b0);
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                end
                check("full_in_ready", 32'(in_ready), 32'd0);
                check("full_accepted", 32'(in_acc - base), 32'd9);
                check("full_wr_valid", 32'(wr_valid), 32'd1);
                wr_rand = 1'b1;
            end
        join
        wr_rand = 1'b0;
        wr_val  = 1'b1;
        wait_idle("full_drain", 200);

        // Illegal opcode, then ERASE 03 0A 00 00
        send_frame(4'h5, 2'd0, 24'h0, 1, 1'b0);
        send_frame(4'h3, 2'd0, 24'h0A0000, 1, 1'b0);
        wait_idle("erase_idle", 100);
        check("err_op_once", 32'(err_op_seen), 32'd1);

        // 256-byte boundary and random traffic with random consumer readiness
        rr_rand = 1'b1;
        wr_rand = 1'b1;
        send_frame(4'h1, 2'd1, 24'hFFFFFF, 256, 1'b0);
        send_frame(4'h2, 2'd2, 24'h800000, 256, 1'b0);
        for (int f = 0; f < 30; f++) begin
            logic [3:0] opn;
            int len;
            opn = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(1, 3));
            len = ($urandom_range(0, 7) == 0) ? 256 : $urandom_range(1, 12);
            send_frame(opn, 2'($urandom_range(0, 3)), 24'($urandom), len, 1'b0);
        end
        wait_idle("random_drain", 10000);
        check("err_op_total", 32'(err_op_seen), 32'(exp_err_op));
        rr_rand = 1'b0;
        wr_rand = 1'b0;
        rr_val  = 1'b1;
        wr_val  = 1'b1;

`ifdef MEM_DEFRAMER_TIMEOUT_EN
        send_byte(8'h01);
        send_byte(8'h12);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_timeout && n < 400);
        check("to_latency", 32'(n), 32'd256);
        check("to_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("to_pulse_width", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #1;
        send_frame(4'h1, 2'd0, 24'h123456, 16, 1'b0);
        wait_idle("to_recover", 100);
        check("to_count", 32'(err_to_seen), 32'd1);
`else
        check("to_never", 32'(err_to_seen), 32'd0);
`endif

        // Reset in the middle of a payload
        wr_val = 1'b0;
        exp_desc.push_back('{op: 2'd2, addr: 24'h000010, len: 9'd4, src: 2'd1});
        send_byte(8'h42);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h03);
        send_byte(8'h5A);
        send_byte(8'hA5);
        @(posedge clk);
        #1;
        check("mid_wr_valid", 32'(wr_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_wr_valid", 32'(wr_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_req", 32'({req_valid, req_op, req_len}), 32'd0);
        check("mid_rst_addr", 32'(req_addr), 32'd0);
        check("mid_rst_errs", 32'({err_opcode, err_timeout}), 32'd0);
        exp_wr.delete();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        wr_val = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_wr_valid", 32'(wr_valid), 32'd0);
        send_frame(4'h1, 2'd3, 24'h654321, 7, 1'b0);
        wait_idle("post_rst_idle", 100);
        check("desc_queue_empty", 32'(exp_desc.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
